// File: rtl/zle_stream_arb.sv
// ---------------------------------------------------------------------------
// zle_stream_arb
//
// Purpose:
//   Shares a single ZLE encoder between N_CH independent token streams.
//   One channel at a time is granted in round-robin order. The granted
//   channel's valid/back-pressure/data are forwarded combinationally to the
//   encoder. The grant only moves while the encoder sits in its start state,
//   so a zero run, and the pending token that closes it, always belong to one
//   channel. The grant output therefore tags every encoder output token.
//
// Optional feature (macro ZLE_ARB_STARVE_EN):
//   Adds the STARVE_MAX parameter and the registered 'starve' output. It
//   pulses once when the granted channel has left the encoder stuck in the
//   zeros state with no data for STARVE_MAX consecutive cycles.
//
// Ports:
//   clock      in   1          clock, all state on rising edge
//   reset      in   1          asynchronous, active-low reset
//   in_v       in   N_CH       per-channel token valid
//   in_b       out  N_CH       per-channel back-pressure, 1 = stall
//   in_d       in   N_CH*W     per-channel data, channel k at [k*W +: W]
//   enc_i_v    out  1          valid to encoder input stream
//   enc_i_b    in   1          back-pressure from encoder input stream
//   enc_i_d    out  W          data to encoder
//   enc_state  in   2          encoder state: 0 start, 1 zeros, 2 pending
//   grant      out  clog2(N_CH) current owner, tags encoder output tokens
//   grant_v    out  1          grant is valid
//   starve     out  1          (ZLE_ARB_STARVE_EN only) starvation pulse
// ---------------------------------------------------------------------------
module zle_stream_arb #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int QUANTUM    = 8,
    parameter int CW         = 8
`ifdef ZLE_ARB_STARVE_EN
    ,
    parameter int STARVE_MAX = 64
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CH-1:0]           in_v,
    output logic [N_CH-1:0]           in_b,
    input  logic [N_CH*W-1:0]         in_d,
    output logic                      enc_i_v,
    input  logic                      enc_i_b,
    output logic [W-1:0]              enc_i_d,
    input  logic [1:0]                enc_state,
    output logic [$clog2(N_CH)-1:0]   grant,
    output logic                      grant_v
`ifdef ZLE_ARB_STARVE_EN
    ,
    output logic                      starve
`endif
);

    localparam int              GW   = $clog2(N_CH);
    localparam logic [CW-1:0]   QCNT = CW'(QUANTUM);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_pick_next;
    logic            w_gv;
    logic [W-1:0]    w_gd;
    logic            w_release;
    logic            w_xfer;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    // The wrap is a subtraction rather than a modulo so that non-power-of-two
    // channel counts stay cheap.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!w_found && in_v[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    assign w_pick_next = (w_pick == GW'(N_CH - 1)) ? '0 : w_pick + 1'b1;

    // Granted channel's request and data.
    assign w_gv = in_v[r_grant];
    assign w_gd = in_d[r_grant*W +: W];

    // The grant may only drop while the encoder is in start, so a zero run
    // or its pending token is never split from the channel that produced it.
    assign w_release = (r_state == ST_GRANT) && (enc_state == 2'd0) &&
                       ((r_cnt == QCNT) || !w_gv);

    assign w_xfer = enc_i_v && !enc_i_b;

    // Next state and forwarding path. The release cycle blocks the transfer
    // so the token counted against the quantum is never half-accepted.
    always_comb begin
        w_state_next = r_state;
        in_b         = '1;
        enc_i_v      = 1'b0;
        enc_i_d      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                enc_i_d = w_gd;
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end else begin
                    enc_i_v       = w_gv;
                    in_b[r_grant] = enc_i_b;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and quantum counter. The grant holds
    // its last value through IDLE so late encoder outputs keep a stable tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_found) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_pick_next;
                r_cnt    <= '0;
            end else if ((r_state == ST_GRANT) && w_xfer && (r_cnt != QCNT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign grant   = r_grant;
    assign grant_v = (r_state == ST_GRANT);

`ifdef ZLE_ARB_STARVE_EN
    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic [7:0] r_starve_tmr;
    logic       r_starve;
    logic       w_starve_cond;

    // Encoder parked in zeros while the owner has nothing to send. Any
    // transfer implies in_v[g]=1, so it clears the timer along with leaving
    // GRANT.
    assign w_starve_cond = (r_state == ST_GRANT) && (enc_state == 2'd1) && !w_gv;

    // Timer saturates at STARVE_MAX so the pulse fires once per episode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_tmr <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_starve <= 1'b0;
            if (!w_starve_cond) begin
                r_starve_tmr <= '0;
            end else if (r_starve_tmr != SMAX) begin
                r_starve_tmr <= r_starve_tmr + 8'd1;
                if ((r_starve_tmr + 8'd1) == SMAX) begin
                    r_starve <= 1'b1;
                end
            end
        end
    end

    assign starve = r_starve;
`endif

endmodule

// File: tb/tb_zle_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_zle_stream_arb
//
// Bench for zle_stream_arb with N_CH=4, W=8, QUANTUM=4. A cycle-by-cycle
// vector table drives the arbiter directly, with a hand-driven encoder
// state. Multi-cycle scenarios use a small ZLE encoder model and per-channel
// token sources.
// ---------------------------------------------------------------------------
module tb_zle_stream_arb;

   localparam int N_CH    = 4;
   localparam int W       = 8;
   localparam int QUANTUM = 4;
   localparam int CW      = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [N_CH-1:0]   in_v;
   logic [N_CH-1:0]   in_b;
   logic [N_CH*W-1:0] in_d;
   logic              enc_i_v;
   logic              enc_i_b;
   logic [W-1:0]      enc_i_d;
   logic [1:0]        enc_state;
   logic [1:0]        grant;
   logic              grant_v;
`ifdef ZLE_ARB_STARVE_EN
   logic              starve;
`endif

   int checks = 0;
   int errors = 0;

   // Source selection: the vector table or the token sources plus encoder model
   logic        useModel    = 1'b0;
   logic [3:0]  tblInV      = 4'h0;
   logic [31:0] tblInD      = 32'h44332211;
   logic        tblEncB     = 1'b0;
   logic [1:0]  tblEncState = 2'd0;
   logic        tbStall     = 1'b0;

   // Per-channel token sources
   logic [7:0]  srcTok [4][32];
   int          srcLen [4];
   int          srcIdx [4];
   logic [3:0]  srcInV;
   logic [31:0] srcInD;

   // Encoder model state and logs
   logic [1:0]  mState;
   int          runLen;
   logic [7:0]  pendData;
   int          cyc;
   int          nX;
   int          xferCh  [64];
   int          xferCyc [64];
   int          nOut;
   int          outData [16];
   int          outTag  [16];

   always #5 clock = ~clock;

   assign in_v      = useModel ? srcInV : tblInV;
   assign in_d      = useModel ? srcInD : tblInD;
   assign enc_state = useModel ? mState : tblEncState;
   assign enc_i_b   = useModel ? (tbStall || (mState == 2'd2)) : tblEncB;

   zle_stream_arb #(
      .N_CH(N_CH), .W(W), .QUANTUM(QUANTUM), .CW(CW)
`ifdef ZLE_ARB_STARVE_EN
      , .STARVE_MAX(8)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .in_v(in_v),
      .in_b(in_b),
      .in_d(in_d),
      .enc_i_v(enc_i_v),
      .enc_i_b(enc_i_b),
      .enc_i_d(enc_i_d),
      .enc_state(enc_state),
      .grant(grant),
      .grant_v(grant_v)
`ifdef ZLE_ARB_STARVE_EN
      , .starve(starve)
`endif
   );

   // Source front tokens: a channel requests while it has tokens left
   always_comb begin
      srcInV = '0;
      srcInD = '0;
      for (int k = 0; k < 4; k++) begin
         if (srcIdx[k] < srcLen[k] && srcIdx[k] < 32) begin
            srcInV[k]         = 1'b1;
            srcInD[k*8 +: 8]  = srcTok[k][srcIdx[k]];
         end
      end
   end

   // ZLE encoder model: zeros collapse into a run-length token that is
   // emitted when the first nonzero token arrives. That nonzero token is
   // held one cycle in pending, with input stalled, and then emitted.
   // Transfers and outputs are logged with the grant tag.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mState   <= 2'd0;
         runLen   <= 0;
         pendData <= 8'h00;
         cyc      <= 0;
         nX       <= 0;
         nOut     <= 0;
         for (int k = 0; k < 4; k++) srcIdx[k] <= 0;
      end else begin
         cyc <= cyc + 1;
         if (useModel) begin
            for (int k = 0; k < 4; k++) begin
               if (in_v[k] && !in_b[k]) srcIdx[k] <= srcIdx[k] + 1;
            end
            if (mState == 2'd2) begin
               if (nOut < 16) begin
                  outData[nOut] <= int'(pendData);
                  outTag[nOut]  <= int'(grant);
               end
               nOut   <= nOut + 1;
               mState <= 2'd0;
            end else if (enc_i_v && !enc_i_b) begin
               if (nX < 64) begin
                  xferCh[nX]  <= int'(grant);
                  xferCyc[nX] <= cyc;
               end
               nX <= nX + 1;
               if (enc_i_d == 8'h00) begin
                  runLen <= (mState == 2'd0) ? 1 : runLen + 1;
                  mState <= 2'd1;
               end else if (mState == 2'd1) begin
                  if (nOut < 16) begin
                     outData[nOut] <= runLen;
                     outTag[nOut]  <= int'(grant);
                  end
                  nOut     <= nOut + 1;
                  pendData <= enc_i_d;
                  mState   <= 2'd2;
               end else begin
                  if (nOut < 16) begin
                     outData[nOut] <= int'(enc_i_d);
                     outTag[nOut]  <= int'(grant);
                  end
                  nOut <= nOut + 1;
               end
            end
         end
      end
   end

   typedef struct {
      logic [3:0] inV;
      logic       encB;
      logic [1:0] encSt;
      logic [3:0] expInB;
      logic       expV;
      logic [7:0] expD;
      logic [1:0] expG;
      logic       expGv;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input logic [3:0] v, input logic b, input logic [1:0] s,
                               input logic [3:0] eb, input logic ev, input logic [7:0] ed,
                               input logic [1:0] eg, input logic egv);
      vec_t r;
      r.inV = v; r.encB = b; r.encSt = s;
      r.expInB = eb; r.expV = ev; r.expD = ed; r.expG = eg; r.expGv = egv;
      return r;
   endfunction

   function automatic logic [31:0] outPack();
      return {16'h0, in_b, enc_i_v, enc_i_d, grant, grant_v};
   endfunction

   task automatic applyStimulus(input vec_t v);
      tblInV      = v.inV;
      tblEncB     = v.encB;
      tblEncState = v.encSt;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      int expCh2 [12];
      int expCh3 [9];
      int expOutD [4];
      int expOutT [4];
`ifdef ZLE_ARB_STARVE_EN
      int pulses;
      int starveCyc;
`endif

      // Packed order: in_b, enc_i_v, enc_i_d, grant, grant_v
      vecs[0]  = mk(4'h1, 0, 0, 4'hF, 0, 8'h00, 0, 0); // IDLE sees ch0
      vecs[1]  = mk(4'h1, 0, 0, 4'hE, 1, 8'h11, 0, 1); // cnt 0->1
      vecs[2]  = mk(4'h1, 1, 0, 4'hF, 1, 8'h11, 0, 1); // stalled
      vecs[3]  = mk(4'h1, 1, 0, 4'hF, 1, 8'h11, 0, 1); // stalled
      vecs[4]  = mk(4'h1, 0, 0, 4'hE, 1, 8'h11, 0, 1); // cnt 1->2
      vecs[5]  = mk(4'h5, 0, 0, 4'hE, 1, 8'h11, 0, 1); // ch2 requests, cnt 2->3
      vecs[6]  = mk(4'h5, 0, 0, 4'hE, 1, 8'h11, 0, 1); // cnt 3->4
      vecs[7]  = mk(4'h5, 0, 1, 4'hE, 1, 8'h11, 0, 1); // zeros: held past quantum
      vecs[8]  = mk(4'h4, 0, 1, 4'hE, 0, 8'h11, 0, 1); // owner idle in zeros: held
      vecs[9]  = mk(4'h4, 0, 2, 4'hE, 0, 8'h11, 0, 1); // pending: held
      vecs[10] = mk(4'h4, 0, 3, 4'hE, 0, 8'h11, 0, 1); // illegal: held
      vecs[11] = mk(4'h5, 0, 0, 4'hF, 0, 8'h11, 0, 1); // release cycle
      vecs[12] = mk(4'h5, 0, 0, 4'hF, 0, 8'h00, 0, 0); // IDLE, rr=1 picks ch2
      vecs[13] = mk(4'h5, 0, 0, 4'hB, 1, 8'h33, 2, 1);
      vecs[14] = mk(4'h5, 0, 0, 4'hB, 1, 8'h33, 2, 1);
      vecs[15] = mk(4'h1, 0, 0, 4'hF, 0, 8'h33, 2, 1); // ch2 drops: early release
      vecs[16] = mk(4'h9, 0, 0, 4'hF, 0, 8'h00, 2, 0); // IDLE, rr=3 picks ch3
      vecs[17] = mk(4'h9, 1, 0, 4'hF, 1, 8'h44, 3, 1);
      vecs[18] = mk(4'h9, 0, 0, 4'h7, 1, 8'h44, 3, 1);
      vecs[19] = mk(4'h9, 0, 0, 4'h7, 1, 8'h44, 3, 1);
      vecs[20] = mk(4'h9, 0, 0, 4'h7, 1, 8'h44, 3, 1);
      vecs[21] = mk(4'h9, 0, 0, 4'h7, 1, 8'h44, 3, 1); // cnt reaches 4
      vecs[22] = mk(4'h9, 0, 0, 4'hF, 0, 8'h44, 3, 1); // release the cycle after
      vecs[23] = mk(4'h9, 0, 0, 4'hF, 0, 8'h00, 3, 0); // IDLE, rr wraps to 0
      vecs[24] = mk(4'h9, 0, 0, 4'hE, 1, 8'h11, 0, 1);

      for (int k = 0; k < 4; k++) srcLen[k] = 0;

      // Reset held with every channel requesting
      useModel = 1'b0;
      tblInV   = 4'hF;
      reset    = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("reset_state", outPack(), {16'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b0});
      tblInV = 4'h0;
      reset  = 1'b1;

      $display("[TB] vector table");
      for (int i = 0; i < 25; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d", i), outPack(),
                     {16'h0, vecs[i].expInB, vecs[i].expV, vecs[i].expD,
                      vecs[i].expG, vecs[i].expGv});
         @(negedge clock);
      end

      // Asynchronous reset in the middle of a grant
      #2 reset = 1'b0;
      #1;
      checkOutput("reset_mid_grant", outPack(), {16'h0, 4'hF, 1'b0, 8'h00, 2'd0, 1'b0});

      // Round robin between ch0 and ch2 with nonzero streams
      $display("[TB] round robin");
      useModel = 1'b1;
      for (int k = 0; k < 4; k++) srcLen[k] = 0;
      for (int j = 0; j < 16; j++) begin
         srcTok[0][j] = 8'(8'h10 + j);
         srcTok[2][j] = 8'(8'h30 + j);
      end
      srcLen[0] = 16;
      srcLen[2] = 16;
      @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      expCh2 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
      checkOutput("rr_enough_xfers", 32'(nX >= 12), 32'd1);
      if (nX >= 12) begin
         for (int i = 0; i < 12; i++)
            checkOutput($sformatf("rr_ch%0d", i), 32'(xferCh[i]), 32'(expCh2[i]));
         checkOutput("rr_back_to_back", 32'(xferCyc[1] - xferCyc[0]), 32'd1);
         checkOutput("rr_gap1", 32'(xferCyc[4] - xferCyc[3]), 32'd3);
         checkOutput("rr_gap2", 32'(xferCyc[8] - xferCyc[7]), 32'd3);
      end

      // Zero run on ch1 crossing the quantum while ch3 waits
      $display("[TB] zero run across quantum");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) srcLen[k] = 0;
      for (int j = 0; j < 6; j++) srcTok[1][j] = 8'h00;
      srcTok[1][6] = 8'h05;
      srcLen[1]    = 7;
      srcTok[3][0] = 8'h44;
      srcTok[3][1] = 8'h45;
      srcLen[3]    = 2;
      @(negedge clock);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      expCh3  = '{1, 1, 1, 1, 1, 1, 1, 3, 3};
      expOutD = '{6, 5, 'h44, 'h45};
      expOutT = '{1, 1, 3, 3};
      checkOutput("zr_xfer_count", 32'(nX), 32'd9);
      checkOutput("zr_out_count", 32'(nOut), 32'd4);
      if (nX == 9 && nOut == 4) begin
         for (int i = 0; i < 9; i++)
            checkOutput($sformatf("zr_ch%0d", i), 32'(xferCh[i]), 32'(expCh3[i]));
         checkOutput("zr_switch_gap", 32'(xferCyc[7] - xferCyc[6]), 32'd4);
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("zr_out_data%0d", i), 32'(outData[i]), 32'(expOutD[i]));
            checkOutput($sformatf("zr_out_tag%0d", i), 32'(outTag[i]), 32'(expOutT[i]));
         end
      end

`ifdef ZLE_ARB_STARVE_EN
      // ch0 leaves the encoder in zeros and goes quiet
      $display("[TB] starve");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) srcLen[k] = 0;
      srcTok[0][0] = 8'h00;
      srcLen[0]    = 1;
      pulses       = 0;
      starveCyc    = -1;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (starve === 1'b1) begin
            pulses++;
            if (starveCyc < 0) starveCyc = cyc;
         end
      end
      checkOutput("starve_pulses", 32'(pulses), 32'd1);
      checkOutput("starve_xfers", 32'(nX), 32'd1);
      if (nX == 1)
         checkOutput("starve_timing", 32'(starveCyc - xferCyc[0]), 32'd9);
      checkOutput("starve_grant_held", {30'h0, grant_v, grant[0]}, {30'h0, 1'b1, 1'b0});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/zle_stream_arb.md
Name: zle_stream_arb

Overview:
- Shares one ZLE encoder (start/zeros/pending FSM plus datapath) between N_CH independent input token streams.
- Grants one channel at a time in round-robin order and forwards that channel's valid/back/data to the encoder.
- Switches channel only when the encoder is in its start state, so a zero run never spans two channels.
- Drives a channel tag that accompanies every encoder output token.

Parameters:
N_CH, 4, number of requesting input streams (2..16)
W, 8, token data width
QUANTUM, 8, accepted tokens per grant before a switch is allowed (1..255)
CW, 8, width of the quantum counter (must hold QUANTUM)

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_v  in  N_CH  per-channel token valid
in_b  out  N_CH  per-channel back-pressure, 1 = stall
in_d  in  N_CH*W  per-channel data, channel k at bits [k*W +: W]
enc_i_v  out  1  valid to encoder input stream
enc_i_b  in  1  back-pressure from encoder input stream
enc_i_d  out  W  data to encoder
enc_state  in  2  encoder state: 0 start, 1 zeros, 2 pending, 3 illegal
grant  out  $clog2(N_CH)  current owner; tags encoder output tokens
grant_v  out  1  grant is valid

Behaviour:
- Reset and clock:
  - Single clock domain.
  - reset low asynchronously forces: FSM IDLE, grant=0, grant_v=0, rr_ptr=0, cnt=0.
  - Because of that reset state, all in_b are 1, enc_i_v=0 and enc_i_d=0 while reset is asserted.
- Handshake:
  - A transfer occurs when v && !b in the same cycle.
  - in_b of every non-granted channel is 1.
- FSM IDLE:
  - grant_v=0, enc_i_v=0.
  - Round-robin search starts at rr_ptr and wraps modulo N_CH; it picks the first k with in_v[k]=1.
  - If a requester is found, next cycle: grant=k, grant_v=1, cnt=0, rr_ptr=(k+1) mod N_CH, state GRANT.
  - If none is found, stay in IDLE.
- FSM GRANT, forwarding path (g = grant):
  - enc_i_v=in_v[g], enc_i_d=in_d[g], in_b[g]=enc_i_b.
  - On each transfer, cnt increments and saturates at QUANTUM.
- FSM GRANT, release condition:
  - Release when enc_state==0 and (cnt==QUANTUM or in_v[g]==0).
  - The condition is evaluated on current-cycle values.
  - In the release cycle, enc_i_v is forced 0 and in_b[g] is forced 1, so no transfer happens.
  - Next cycle: state IDLE, grant_v=0, grant holds its last value.
- Grant hold rules:
  - enc_state 1 (zeros): the grant is held even if the quantum has expired or in_v[g] drops. Forwarding continues so the run can terminate.
  - enc_state 2 (pending): the grant is held. The encoder emits its pending token tagged with g, then returns to start.
  - enc_state 3: treated as not-start, so the grant is held.
- Switch overhead:
  - Minimum gap between the last transfer of one grant and the first transfer of the next is 2 cycles (release cycle, then IDLE cycle).
  - With a single active channel, that channel is re-granted after the gap.
- Latency and tag stability:
  - IDLE to first possible transfer is 1 cycle after the request is seen.
  - Forwarding is combinational, zero latency.
  - grant is stable whenever enc_state!=0, so it correctly tags the encoder's o_v tokens, including pending-state outputs.
- Boundary conditions:
  - QUANTUM=1: release is possible after every token that leaves the encoder in start.
  - in_v of a non-granted channel may toggle freely with no effect.
  - Simultaneous transfer and cnt reaching QUANTUM: release is evaluated in the following cycle.
  - Reset mid-grant: the grant is dropped immediately. The encoder is reset by the same reset net.

Optional Feature:
- Macro: ZLE_ARB_STARVE_EN.
- With the macro defined:
  - Adds parameter STARVE_MAX (default 64) and output starve (1 bit, registered).
  - An 8-bit timer counts consecutive GRANT cycles with enc_state==1 and in_v[g]==0.
  - The timer clears on any transfer or on leaving GRANT.
  - starve pulses high for 1 cycle when the timer reaches STARVE_MAX, then the timer saturates until cleared.
  - starve resets to 0.
- Without the macro: no timer and no starve port. Behaviour is otherwise identical.

Test Plan:
(All with N_CH=4, W=8, QUANTUM=4; encoder model attached.)
1. Reset: hold reset low with in_v=4'hF -> in_b=4'hF, enc_i_v=0, grant_v=0. Release reset -> grant=0 and grant_v=1 one cycle after IDLE samples.
2. Round-robin: channels 0 and 2 stream nonzero tokens continuously, enc_i_b=0 -> transfers in the order ch0 x4, 2-cycle gap, ch2 x4, gap, ch0 x4; grant alternates 0,2,0.
3. Zero run across quantum: ch1 sends 6 zeros then 8'h05 while ch3 requests -> grant stays 1 through all 7 tokens and the pending output. Encoder outputs are tagged grant=1. Switch to ch3 occurs only after enc_state returns to 0.
4. Back-pressure: enc_i_b=1 for 3 cycles during a ch0 grant -> in_b[0]=1 for those cycles, cnt unchanged, no extra tokens counted.
5. Early release: ch2 drops in_v after 2 tokens with enc_state=0 -> release cycle then IDLE; grant moves to the next requester via rr_ptr=3.
6. Starve (ZLE_ARB_STARVE_EN, STARVE_MAX=8): ch0 sends 1 zero then idles -> starve pulses exactly once, 8 cycles after the zeros state was entered. The grant is held.
